// File: rtl/mem_store_buf.sv
// Store write buffer in front of a single-port data memory. Loads win the port, buffered stores drain in idle cycles.
// Load data is combinational. Forwarding is youngest-first. o_st_ready drops when full; o_ld_ready drops only on a forced drain.
module mem_store_buf #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_ADDR_LEN     = 10,
  parameter int p_DEPTH        = 4,
  parameter int p_STARVE_LIMIT = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_st_valid,
  input  logic [p_ADDR_LEN-1:0]        i_st_addr,
  input  logic [p_WORD_LEN-1:0]        i_st_data,
  output logic                         o_st_ready,
  input  logic                         i_ld_valid,
  input  logic [p_ADDR_LEN-1:0]        i_ld_addr,
  output logic                         o_ld_ready,
  output logic [p_WORD_LEN-1:0]        o_ld_data,
  output logic [p_ADDR_LEN-1:0]        o_mem_addr,
  output logic                         o_mem_wr_en,
  output logic [p_WORD_LEN-1:0]        o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0]        i_mem_rd_data,
  output logic [$clog2(p_DEPTH):0]     o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int P_PTR = $clog2(p_DEPTH);
  localparam int P_CNT = P_PTR + 1;
  localparam int P_SC  = $clog2(p_STARVE_LIMIT + 1);

  logic [p_ADDR_LEN-1:0] addr_q [p_DEPTH];
  logic [p_WORD_LEN-1:0] data_q [p_DEPTH];
  logic [P_PTR-1:0]      head_q;
  logic [P_PTR-1:0]      tail_q;
  logic [P_CNT-1:0]      count_q;
  logic [P_SC-1:0]       starve_q;

  logic                  empty;
  logic                  full;
  logic                  force_drain;
  logic                  drain;
  logic                  push;
  logic [P_PTR-1:0]      idx;
  logic [p_WORD_LEN-1:0] fwd_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == P_CNT'(p_DEPTH));
  assign force_drain = (starve_q == P_SC'(p_STARVE_LIMIT)) && !empty;
  assign drain       = !empty && (!i_ld_valid || force_drain);
  assign push        = i_st_valid && !full;

  assign o_st_ready    = !full;
  assign o_ld_ready    = !(i_ld_valid && force_drain);
  assign o_mem_wr_en   = drain;
  assign o_mem_wr_data = data_q[head_q];
  assign o_mem_addr    = drain ? addr_q[head_q] : i_ld_addr;
  assign o_ld_data     = fwd_data;
  assign o_count       = count_q;
  assign o_empty       = empty;
  assign o_full        = full;

  // Walk oldest to youngest so the last match is the most recent store.
  always_comb begin
    fwd_data = i_mem_rd_data;
    idx      = head_q;
    for (int i = 0; i < p_DEPTH; i++) begin
      idx = head_q + P_PTR'(i);
      if ((P_CNT'(i) < count_q) && (addr_q[idx] == i_ld_addr)) begin
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      case ({push, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A non-empty buffer that did not drain must have lost the port to a load.
      if (drain || empty) begin
        starve_q <= '0;
      end else if (i_ld_valid && (starve_q != P_SC'(p_STARVE_LIMIT))) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Payload needs no reset: entries are only visible below count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[tail_q] <= i_st_addr;
      data_q[tail_q] <= i_st_data;
    end
  end

endmodule

// File: tb/tb_mem_store_buf.sv
module tb_mem_store_buf;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [9:0]  st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [9:0]  ld_addr;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic [9:0]  mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  mem_store_buf dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_st_valid   (st_valid),
    .i_st_addr    (st_addr),
    .i_st_data    (st_data),
    .o_st_ready   (st_ready),
    .i_ld_valid   (ld_valid),
    .i_ld_addr    (ld_addr),
    .o_ld_ready   (ld_ready),
    .o_ld_data    (ld_data),
    .o_mem_addr   (mem_addr),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data),
    .o_count      (count),
    .o_empty      (empty),
    .o_full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of pending stores plus a starvation count.
  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t mq[$];
  int   starve;

  initial begin : compare
    int          n;
    bit          m_empty;
    bit          m_force;
    bit          m_drain;
    bit          m_ldr;
    logic [15:0] exp_ld;
    ent_t        e;
    starve = 0;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        starve = 0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      end else begin
        n       = mq.size();
        m_empty = (n == 0);
        m_force = (starve == LIMIT) && !m_empty;
        m_drain = !m_empty && (!ld_valid || m_force);
        m_ldr   = !(ld_valid && m_force);
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(m_empty));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
        chk("ld_ready", 32'(ld_ready), 32'(m_ldr));
        chk("wr_en", 32'(mem_wr_en), 32'(m_drain));
        if (m_drain) begin
          chk("wr_addr", 32'(mem_addr), 32'(mq[0].a));
          chk("wr_data", 32'(mem_wr_data), 32'(mq[0].d));
        end else begin
          chk("rd_addr", 32'(mem_addr), 32'(ld_addr));
        end
        if (ld_valid && m_ldr) begin
          exp_ld = mem_rd_data;
          foreach (mq[k]) if (mq[k].a == ld_addr) exp_ld = mq[k].d;
          chk("ld_data", 32'(ld_data), 32'(exp_ld));
        end
        if (m_drain || m_empty) starve = 0;
        else if (ld_valid && starve < LIMIT) starve++;
        if (m_drain) void'(mq.pop_front());
        if (st_valid && n < DEPTH) begin
          e.a = st_addr;
          e.d = st_data;
          mq.push_back(e);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_rd_data = '0;
    step();
    step();
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_st_ready", 32'(st_ready), 32'd1);
    step();
    rst = 1'b0;

    // Mid-cycle reset pulse discards a held entry asynchronously.
    ld_valid = 1'b1; ld_addr = 10'h3FF;
    st_valid = 1'b1; st_addr = 10'h0AA; st_data = 16'h1234;
    step();
    st_valid = 1'b0;
    #2 chk("pulse_pre_count", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    chk("pulse_empty", 32'(empty), 32'd1);
    chk("pulse_count", 32'(count), 32'd0);
    chk("pulse_wr_en", 32'(mem_wr_en), 32'd0);
    step();
    rst = 1'b0; ld_valid = 1'b0; ld_addr = 10'h155;
    #2 chk("idle_addr", 32'(mem_addr), 32'h155);
    chk("idle_wr_en", 32'(mem_wr_en), 32'd0);

    // Fill under continuous loads, then drain in order.
    step();
    ld_valid = 1'b1; ld_addr = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 10'(32'h010 + i); st_data = 16'(32'hA000 + i);
      step();
    end
    st_valid = 1'b0;
    #2 chk("fill_full", 32'(full), 32'd1);
    chk("fill_st_ready", 32'(st_ready), 32'd0);
    chk("fill_wr_en", 32'(mem_wr_en), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 chk("drain_wr_en", 32'(mem_wr_en), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h010 + 32'(i));
      chk("drain_data", 32'(mem_wr_data), 32'hA000 + 32'(i));
      step();
    end
    #2 chk("drain_empty", 32'(empty), 32'd1);

    // Youngest-match forwarding and full-width address compare.
    ld_valid = 1'b1; ld_addr = 10'h3FF;
    st_valid = 1'b1; st_addr = 10'h020; st_data = 16'h1111;
    step();
    st_data = 16'h2222;
    step();
    st_valid = 1'b0; ld_addr = 10'h020;
    #2 chk("fwd_young", 32'(ld_data), 32'h2222);
    chk("fwd_ld_ready", 32'(ld_ready), 32'd1);
    step();
    ld_addr = 10'h021; mem_rd_data = 16'hBEEF;
    #2 chk("fwd_miss", 32'(ld_data), 32'hBEEF);
    step();
    ld_addr = 10'h220; mem_rd_data = 16'h0F0F;
    #2 chk("fwd_msb_miss", 32'(ld_data), 32'h0F0F);
    step();
    ld_valid = 1'b0; mem_rd_data = '0;
    step();
    step();
    #2 chk("fwd_empty", 32'(empty), 32'd1);

    // Starvation: eight served loads, then a forced drain.
    ld_valid = 1'b1; ld_addr = 10'h100;
    st_valid = 1'b1; st_addr = 10'h030; st_data = 16'h5555;
    step();
    st_valid = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      #2 chk("starve_ld_ready", 32'(ld_ready), 32'd1);
      chk("starve_wr_en", 32'(mem_wr_en), 32'd0);
      step();
    end
    #2 chk("force_ld_ready", 32'(ld_ready), 32'd0);
    chk("force_wr_en", 32'(mem_wr_en), 32'd1);
    chk("force_addr", 32'(mem_addr), 32'h030);
    step();
    #2 chk("force_empty", 32'(empty), 32'd1);
    chk("force_ld_ready_after", 32'(ld_ready), 32'd1);

    // Simultaneous push and pop with wrap over 3x depth.
    ld_addr = 10'h3FF;
    st_valid = 1'b1; st_addr = 10'h040; st_data = 16'hB000;
    step();
    st_addr = 10'h041; st_data = 16'hB001;
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      st_addr = 10'(32'h050 + i); st_data = 16'(32'hC000 + i);
      #2 chk("pp_count", 32'(count), 32'd2);
      chk("pp_wr_data", 32'(mem_wr_data), (i < 2) ? 32'hB000 + 32'(i) : 32'hC000 + 32'(i - 2));
      step();
    end
    st_valid = 1'b0;
    #2 chk("pp_tail_data", 32'(mem_wr_data), 32'hC000 + 32'(3 * DEPTH - 2));
    step();
    step();
    #2 chk("pp_empty", 32'(empty), 32'd1);

    // Reset in the middle of a drain cycle.
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 10'(32'h060 + i); st_data = 16'(32'hD000 + i);
      step();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    #2 chk("mid_wr_en_pre", 32'(mem_wr_en), 32'd1);
    chk("mid_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    #1 chk("mid_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 chk("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
      step();
    end

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_store_buf.md
Name: mem_store_buf

Overview:
- Write buffer between the core's load/store datapath and the data memory (`mem_data`).
- Queues stores in a FIFO and drains them to the memory's single address/write port in cycles with no load.
- Loads use the port first; matching buffered stores are forwarded to them.
- A starvation counter guarantees forward progress of drains.

Parameters:
- p_WORD_LEN, 16, bits per data word.
- p_ADDR_LEN, 10, address width; matches data memory.
- p_DEPTH, 4, buffer entries; power of two, ≥2.
- p_STARVE_LIMIT, 8, consecutive load-blocked cycles, with buffer non-empty, before a drain is forced.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  asynchronous active-high reset.
- i_st_valid  in  1  store request.
- i_st_addr  in  p_ADDR_LEN  store address.
- i_st_data  in  p_WORD_LEN  store data.
- o_st_ready  out  1  store accepted at posedge when i_st_valid && o_st_ready.
- i_ld_valid  in  1  load request.
- i_ld_addr  in  p_ADDR_LEN  load address.
- o_ld_ready  out  1  load served this cycle; core stalls while low.
- o_ld_data  out  p_WORD_LEN  load result, combinational.
- o_mem_addr  out  p_ADDR_LEN  to memory address.
- o_mem_wr_en  out  1  to memory write enable.
- o_mem_wr_data  out  p_WORD_LEN  to memory write data.
- i_mem_rd_data  in  p_WORD_LEN  from memory asynchronous read data.
- o_count  out  $clog2(p_DEPTH)+1  occupied entries.
- o_empty  out  1  count == 0; used by the core as a fence.
- o_full  out  1  count == p_DEPTH.

Behaviour:
- Reset: while i_rst is high, and immediately on assertion:
  - head, tail, count and starve counter go to 0; all entries are discarded, including one mid-drain.
  - o_mem_wr_en=0, o_st_ready=1, o_ld_ready=1, o_empty=1, o_full=0, o_count=0.
- Storage: circular FIFO of {addr, data}; head/tail pointers wrap modulo p_DEPTH; count register held separately.
- o_st_ready = !o_full. This is registered-state only; there is no same-cycle pass-through on drain.
- Push: on posedge when i_st_valid && o_st_ready, write the entry at tail and advance tail.
  - Duplicate addresses are not coalesced; each store is a separate entry.
- Port arbitration, each cycle (combinational from registered state and i_ld_valid):
  - force = (starve_cnt == p_STARVE_LIMIT) && !o_empty.
  - drain = !o_empty && (!i_ld_valid || force).
  - o_ld_ready = !(i_ld_valid && force). o_ld_ready is 1 when no load is requested.
  - o_mem_wr_en = drain. o_mem_wr_data = head data.
  - o_mem_addr = head addr when drain, else i_ld_addr.
- Pop: on posedge when drain, advance head. The memory commits on the mid-cycle negedge, so the entry is written before removal.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - Push with buffer full is impossible, because o_st_ready = 0.
- Starve counter:
  - Increments on each posedge where !o_empty && i_ld_valid && !force, saturating at p_STARVE_LIMIT.
  - Clears to 0 on any drain, and whenever the buffer is empty.
- Forwarding: o_ld_data is the data of the youngest valid entry whose addr == i_ld_addr; otherwise i_mem_rd_data.
  - Entries are only those present at the start of the cycle; a store accepted in the same cycle is not visible.
  - During a forced drain o_ld_data is don't-care, because o_ld_ready = 0.
- Write ordering: memory receives stores in program order; one write per drain cycle maximum.
- Addresses are used at full p_ADDR_LEN width in comparisons; no truncation.

Test Plan:
- Reset then idle: i_rst pulse mid-cycle → o_empty=1, o_count=0, o_mem_wr_en=0 asynchronously. After release with no requests, the memory address follows i_ld_addr.
- Fill and drain:
  - With i_ld_valid held 1 (≤7 cycles), push stores to 0x010..0x013 with data 0xA000..0xA003 → o_full=1, o_st_ready=0, no writes.
  - Drop i_ld_valid → four consecutive writes, addr 0x010..0x013 in order; o_empty=1 after the fourth posedge.
- Forwarding youngest:
  - Buffer holds {0x020:0x1111, 0x020:0x2222}; load 0x020 → o_ld_data=0x2222, o_ld_ready=1.
  - Load 0x021 with i_mem_rd_data=0xBEEF → o_ld_data=0xBEEF.
- Starvation:
  - One entry {0x030:0x5555}, i_ld_valid held 1 → 8 cycles of o_ld_ready=1.
  - 9th cycle: o_ld_ready=0, o_mem_wr_en=1, addr 0x030. Next cycle o_empty=1, o_ld_ready=1.
- Push/pop same cycle with count=2: store valid and no load → o_count stays 2; pointers wrap correctly over 3×p_DEPTH operations with data integrity checked against a scoreboard.
- Reset mid-operation: count=3, assert i_rst during a drain cycle → o_mem_wr_en drops immediately, o_count=0; no further writes after release.
